input_conditioner: RTL and testbench

Input-side conditioning stage that sits directly upstream of `comm`'s `input_pins` port. It takes the asynchronous console input pins and passes each one through a two-flop synchronizer and a per-pin stability (debounce) filter. The result drives `comm`'s pin mux, so mapped outputs never see metastable or bouncing levels. Each pin also reports committed level changes as one-cycle pulses for event or status use.

---
 rtl/input_conditioner.sv | 77 +++++++
 tb/tb_input_conditioner.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Input pin conditioner: two-flop synchronizer plus per-pin debounce
// filter with registered change pulses, feeding comm's input pin mux.
module input_conditioner #(
    parameter int   WIDTH           = 4,
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pins_in,
    input  logic             bypass,
    output logic [WIDTH-1:0] pins_out,
    output logic [WIDTH-1:0] changed,
    output logic             any_changed
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [CW-1:0]    cnt     [WIDTH];
    logic [CW-1:0]    cnt_nxt [WIDTH];
    logic [WIDTH-1:0] out_nxt;
    logic [WIDTH-1:0] chg_nxt;

    // Next-state filter decision per pin; any_changed uses these bits directly
    always_comb begin
        out_nxt = pins_out;
        chg_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = '0;
            if (bypass) begin
                out_nxt[i] = s2[i];
                chg_nxt[i] = (s2[i] != pins_out[i]);
            end else if (s2[i] == pins_out[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] == CNT_MAX) begin
                out_nxt[i] = s2[i];
                chg_nxt[i] = 1'b1;
            end else begin
                cnt_nxt[i] = cnt[i] + CW'(1);
            end
        end
    end

    // Synchronizer chain, runs regardless of bypass
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= {WIDTH{RESET_LEVEL}};
            s2 <= {WIDTH{RESET_LEVEL}};
        end else begin
            s1 <= pins_in;
            s2 <= s1;
        end
    end

    // Committed levels, stability counters and change pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pins_out    <= {WIDTH{RESET_LEVEL}};
            changed     <= '0;
            any_changed <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            pins_out    <= out_nxt;
            changed     <= chg_nxt;
            any_changed <= |chg_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed-vector bench for input_conditioner at default parameters
// (WIDTH=4, DEBOUNCE_CYCLES=16).
module tb_input_conditioner;

    logic       clk;
    logic       rst;
    logic [3:0] pins_in;
    logic       bypass;
    logic [3:0] pins_out;
    logic [3:0] changed;
    logic       any_changed;

    int checks;
    int errors;
    int pulses [4];
    int any_pulses;

    input_conditioner dut (
        .clk         (clk),
        .rst         (rst),
        .pins_in     (pins_in),
        .bypass      (bypass),
        .pins_out    (pins_out),
        .changed     (changed),
        .any_changed (any_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count high cycles of each change output (each pulse is one cycle)
    always @(negedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (changed[b]) pulses[b] = pulses[b] + 1;
        end
        if (any_changed) any_pulses = any_pulses + 1;
    end

    typedef struct {
        logic       rst;
        logic       byp;
        logic [3:0] pins;
        int         n;
        logic [3:0] eo;
        logic [3:0] ec;
        logic       ea;
    } vec_t;

    vec_t tbl [39];

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        any_pulses = 0;
        for (int b = 0; b < 4; b++) pulses[b] = 0;

        // rst byp pins n out chg any
        // reset with all pins high, commit at edge 18 after release
        tbl[0]  = '{1, 0, 4'hF, 0,  4'h0, 4'h0, 0};
        tbl[1]  = '{1, 0, 4'hF, 2,  4'h0, 4'h0, 0};
        tbl[2]  = '{0, 0, 4'hF, 17, 4'h0, 4'h0, 0};
        tbl[3]  = '{0, 0, 4'hF, 1,  4'hF, 4'hF, 1};
        tbl[4]  = '{0, 0, 4'hF, 1,  4'hF, 4'h0, 0};
        tbl[5]  = '{0, 0, 4'h0, 17, 4'hF, 4'h0, 0};
        tbl[6]  = '{0, 0, 4'h0, 1,  4'h0, 4'hF, 1};
        tbl[7]  = '{0, 0, 4'h0, 1,  4'h0, 4'h0, 0};
        // single pin step
        tbl[8]  = '{0, 0, 4'h4, 17, 4'h0, 4'h0, 0};
        tbl[9]  = '{0, 0, 4'h4, 1,  4'h4, 4'h4, 1};
        tbl[10] = '{0, 0, 4'h4, 1,  4'h4, 4'h0, 0};
        // 10-cycle glitch on pin 1
        tbl[11] = '{0, 0, 4'h6, 10, 4'h4, 4'h0, 0};
        tbl[12] = '{0, 0, 4'h4, 20, 4'h4, 4'h0, 0};
        // bounce pin 0: 1,0,1,1,0 then steady 1
        tbl[13] = '{0, 0, 4'h5, 1,  4'h4, 4'h0, 0};
        tbl[14] = '{0, 0, 4'h4, 1,  4'h4, 4'h0, 0};
        tbl[15] = '{0, 0, 4'h5, 2,  4'h4, 4'h0, 0};
        tbl[16] = '{0, 0, 4'h4, 1,  4'h4, 4'h0, 0};
        tbl[17] = '{0, 0, 4'h5, 17, 4'h4, 4'h0, 0};
        tbl[18] = '{0, 0, 4'h5, 1,  4'h5, 4'h1, 1};
        tbl[19] = '{0, 0, 4'h5, 1,  4'h5, 4'h0, 0};
        // bypass: follow at edge 3
        tbl[20] = '{0, 1, 4'h5, 2,  4'h5, 4'h0, 0};
        tbl[21] = '{0, 1, 4'hD, 2,  4'h5, 4'h0, 0};
        tbl[22] = '{0, 1, 4'hD, 1,  4'hD, 4'h8, 1};
        tbl[23] = '{0, 1, 4'hD, 1,  4'hD, 4'h0, 0};
        tbl[24] = '{0, 1, 4'h5, 3,  4'h5, 4'h8, 1};
        tbl[25] = '{0, 1, 4'h5, 1,  4'h5, 4'h0, 0};
        // leave bypass with a difference pending at s2
        tbl[26] = '{0, 1, 4'hD, 2,  4'h5, 4'h0, 0};
        tbl[27] = '{0, 0, 4'hD, 15, 4'h5, 4'h0, 0};
        tbl[28] = '{0, 0, 4'hD, 1,  4'hD, 4'h8, 1};
        tbl[29] = '{0, 0, 4'hD, 1,  4'hD, 4'h0, 0};
        // enter bypass mid-count: commits next edge
        tbl[30] = '{0, 0, 4'h5, 8,  4'hD, 4'h0, 0};
        tbl[31] = '{0, 1, 4'h5, 1,  4'h5, 4'h8, 1};
        tbl[32] = '{0, 0, 4'h5, 1,  4'h5, 4'h0, 0};
        // reset at cnt=12, then full latency again
        tbl[33] = '{0, 0, 4'h7, 14, 4'h5, 4'h0, 0};
        tbl[34] = '{1, 0, 4'h7, 0,  4'h0, 4'h0, 0};
        tbl[35] = '{1, 0, 4'h7, 2,  4'h0, 4'h0, 0};
        tbl[36] = '{0, 0, 4'h7, 17, 4'h0, 4'h0, 0};
        tbl[37] = '{0, 0, 4'h7, 1,  4'h7, 4'h7, 1};
        tbl[38] = '{0, 0, 4'h7, 1,  4'h7, 4'h0, 0};

        rst     = 1'b1;
        bypass  = 1'b0;
        pins_in = 4'hF;
        tick(2);

        for (int i = 0; i < 39; i++) begin
            rst     = tbl[i].rst;
            bypass  = tbl[i].byp;
            pins_in = tbl[i].pins;
            if (tbl[i].n == 0) #1;
            else tick(tbl[i].n);
            chk($sformatf("v%0d pins_out", i), int'(pins_out), int'(tbl[i].eo));
            chk($sformatf("v%0d changed", i), int'(changed), int'(tbl[i].ec));
            chk($sformatf("v%0d any_changed", i), int'(any_changed), int'(tbl[i].ea));
            if (i == 12) chk("glitch pin1 pulses", pulses[1], 2);
            if (i == 19) chk("bounce pin0 pulses", pulses[0], 3);
            if (i == 35) chk("reset pin1 pulses", pulses[1], 2);
        end

        chk("total pulses pin0", pulses[0], 4);
        chk("total pulses pin1", pulses[1], 3);
        chk("total pulses pin2", pulses[2], 4);
        chk("total pulses pin3", pulses[3], 6);
        chk("total any pulses", any_pulses, 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
